// File: rtl/ysyx_22050710_isram.sv
// Instruction SRAM responder: one-cycle fetch latency, byte-strobed preload port, fault capture.
// Optional performance counters are built when YSYX_22050710_ISRAM_PERF_EN is defined.
module ysyx_22050710_isram #(
    parameter int                      SRAM_ADDR_WD = 64,
    parameter int                      SRAM_DATA_WD = 32,
    parameter int                      DEPTH        = 16384,
    parameter logic [SRAM_ADDR_WD-1:0] BASE_ADDR    = SRAM_ADDR_WD'(64'h8000_0000),
    parameter logic [SRAM_DATA_WD-1:0] FILL_INST    = '0
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_inst_sram_en,
    input  logic [SRAM_ADDR_WD-1:0]    i_inst_sram_addr,
    output logic [SRAM_DATA_WD-1:0]    o_inst_sram_rdata,
    input  logic                       i_ld_en,
    input  logic [$clog2(DEPTH)-1:0]   i_ld_idx,
    input  logic [31:0]                i_ld_data,
    input  logic [3:0]                 i_ld_strb,
    output logic                       o_fault,
    output logic [SRAM_ADDR_WD-1:0]    o_fault_addr,
    output logic [63:0]                o_fetch_cnt,
    output logic [31:0]                o_fault_cnt
);

    localparam int                      IDX_W   = $clog2(DEPTH);
    localparam logic [SRAM_ADDR_WD-1:0] LIMIT   = SRAM_ADDR_WD'(4 * DEPTH);
    localparam logic [IDX_W:0]          DEPTH_X = (IDX_W + 1)'(DEPTH);

    logic [SRAM_DATA_WD-1:0] r_mem [DEPTH];

    logic [SRAM_DATA_WD-1:0] r_rdata_p1;
    logic                    r_fault_p1;
    logic [SRAM_ADDR_WD-1:0] r_fault_addr_p1;

    logic [SRAM_ADDR_WD-1:0] w_off;
    logic [IDX_W-1:0]        w_widx;
    logic                    w_misalign;
    logic                    w_oor;
    logic                    w_bad;
    logic                    w_fetch;
    logic                    w_ld_ok;

    // Offset wraps modulo 2^SRAM_ADDR_WD, so addresses below BASE land far out of range.
    assign w_off      = i_inst_sram_addr - BASE_ADDR;
    assign w_widx     = w_off[IDX_W+1:2];
    assign w_misalign = |i_inst_sram_addr[1:0];
    assign w_oor      = (w_off >= LIMIT);
    assign w_bad      = w_misalign | w_oor;
    assign w_fetch    = i_inst_sram_en & ~i_rst;
    assign w_ld_ok    = i_ld_en & ({1'b0, i_ld_idx} < DEPTH_X);

    // Preload path: never reset, so the loader may fill memory while the core is held.
    always_ff @(posedge i_clk) begin
        if (w_ld_ok) begin
            for (int k = 0; k < 4; k++) begin
                if (i_ld_strb[k]) begin
                    r_mem[i_ld_idx][8*k +: 8] <= i_ld_data[8*k +: 8];
                end
            end
        end
    end

    // Fetch stage: synchronous read returns the pre-write word on an index collision.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata_p1      <= '0;
            r_fault_p1      <= 1'b0;
            r_fault_addr_p1 <= '0;
        end else if (i_inst_sram_en) begin
            if (w_bad) begin
                r_rdata_p1 <= FILL_INST;
                r_fault_p1 <= 1'b1;
                if (!r_fault_p1) begin
                    r_fault_addr_p1 <= i_inst_sram_addr;
                end
            end else begin
                r_rdata_p1 <= r_mem[w_widx];
            end
        end
    end

    assign o_inst_sram_rdata = r_rdata_p1;
    assign o_fault           = r_fault_p1;
    assign o_fault_addr      = r_fault_addr_p1;

`ifdef YSYX_22050710_ISRAM_PERF_EN
    logic [63:0] r_fetch_cnt_p1;
    logic [31:0] r_fault_cnt_p1;

    function automatic logic [63:0] sat_inc64(input logic [63:0] v);
        return (&v) ? v : v + 64'd1;
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_fetch_cnt_p1 <= '0;
            r_fault_cnt_p1 <= '0;
        end else if (w_fetch) begin
            r_fetch_cnt_p1 <= sat_inc64(r_fetch_cnt_p1);
            if (w_bad) begin
                r_fault_cnt_p1 <= sat_inc32(r_fault_cnt_p1);
            end
        end
    end

    assign o_fetch_cnt = r_fetch_cnt_p1;
    assign o_fault_cnt = r_fault_cnt_p1;
`else
    assign o_fetch_cnt = '0;
    assign o_fault_cnt = '0;
`endif

endmodule

// File: tb/tb_ysyx_22050710_isram.sv
// Scoreboard bench for ysyx_22050710_isram: directed test-plan sequences followed by random traffic.
module tb_ysyx_22050710_isram;

    localparam int          DEPTH = 16384;
    localparam int          IDX_W = $clog2(DEPTH);
    localparam logic [63:0] BASE  = 64'h8000_0000;
    localparam logic [31:0] FILL  = 32'h0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [63:0]      addr;
    logic [31:0]      rdata;
    logic             ld_en;
    logic [IDX_W-1:0] ld_idx;
    logic [31:0]      ld_data;
    logic [3:0]       ld_strb;
    logic             fault;
    logic [63:0]      fault_addr;
    logic [63:0]      fetch_cnt;
    logic [31:0]      fault_cnt;

    ysyx_22050710_isram dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_inst_sram_en    (en),
        .i_inst_sram_addr  (addr),
        .o_inst_sram_rdata (rdata),
        .i_ld_en           (ld_en),
        .i_ld_idx          (ld_idx),
        .i_ld_data         (ld_data),
        .i_ld_strb         (ld_strb),
        .o_fault           (fault),
        .o_fault_addr      (fault_addr),
        .o_fetch_cnt       (fetch_cnt),
        .o_fault_cnt       (fault_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] rdata;
        logic        fault;
        logic [63:0] faddr;
        logic [63:0] fcnt;
        logic [31:0] flcnt;
    } exp_t;

    exp_t        sb_q[$];
    int          n_checks = 0;
    int          n_err    = 0;

    // Reference state
    logic [31:0] m_mem [int];
    logic [31:0] m_rdata = '0;
    logic        m_fault = 1'b0;
    logic [63:0] m_faddr = '0;
    logic [63:0] m_fcnt  = '0;
    logic [31:0] m_flcnt = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the entry pushed on the previous negedge describes outputs after this posedge.
    always @(posedge clk) begin
        #1;
        if (sb_q.size() > 0) begin
            exp_t e;
            e = sb_q.pop_front();
            chk("rdata", 64'(rdata), 64'(e.rdata));
            chk("fault", 64'(fault), 64'(e.fault));
            chk("fault_addr", fault_addr, e.faddr);
            chk("fetch_cnt", fetch_cnt, e.fcnt);
            chk("fault_cnt", 64'(fault_cnt), 64'(e.flcnt));
        end
    end

    task automatic step(input logic r, input logic e, input logic [63:0] a,
                        input logic l, input int idx, input logic [31:0] d, input logic [3:0] s);
        exp_t        x;
        logic [63:0] off;
        logic        bad;
        logic [31:0] w;
        @(negedge clk);
        rst = r; en = e; addr = a; ld_en = l;
        ld_idx = IDX_W'(idx); ld_data = d; ld_strb = s;
        if (r) begin
            m_rdata = '0; m_fault = 1'b0; m_faddr = '0; m_fcnt = '0; m_flcnt = '0;
        end else if (e) begin
            off = a - BASE;
            bad = (a % 4 != 0) || (off >= 64'(4 * DEPTH));
            if (bad) begin
                m_rdata = FILL;
                if (!m_fault) m_faddr = a;
                m_fault = 1'b1;
            end else begin
                m_rdata = m_mem[int'(off / 4)];
            end
`ifdef YSYX_22050710_ISRAM_PERF_EN
            m_fcnt = m_fcnt + 1;
            if (bad) m_flcnt = m_flcnt + 1;
`endif
        end
        if (l && idx < DEPTH) begin
            w = m_mem.exists(idx) ? m_mem[idx] : 32'h0;
            for (int k = 0; k < 4; k++)
                if (s[k]) w[8*k +: 8] = d[8*k +: 8];
            m_mem[idx] = w;
        end
        x.rdata = m_rdata; x.fault = m_fault; x.faddr = m_faddr;
        x.fcnt = m_fcnt; x.flcnt = m_flcnt;
        sb_q.push_back(x);
    endtask

    task automatic fetch(input logic [63:0] a);
        step(1'b0, 1'b1, a, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 64'h0, 1'b0, 0, 32'h0, 4'h0);
    endtask

    task automatic load(input logic r, input int idx, input logic [31:0] d);
        step(r, 1'b0, 64'h0, 1'b1, idx, d, 4'hF);
    endtask

    logic [63:0] ra;
    logic [3:0]  rs;

    initial begin
        rst = 1'b1; en = 1'b0; addr = '0; ld_en = 1'b0;
        ld_idx = '0; ld_data = '0; ld_strb = '0;

        // Preload while held in reset; fetches during reset are ignored.
        for (int i = 0; i < 64; i++) load(1'b1, i, $urandom);
        load(1'b1, DEPTH - 1, 32'hCAFE_F00D);
        step(1'b1, 1'b1, BASE, 1'b0, 0, 32'h0, 4'h0);
        load(1'b0, 0, 32'h0000_0413);
        load(1'b0, 1, 32'h0010_0073);
        load(1'b0, 5, 32'h1122_3344);

        fetch(BASE);
        fetch(BASE + 4);
        fetch(BASE);
        idle(); idle(); idle();
        fetch(BASE + 2);
        fetch(64'h7FFF_FFFC);
        fetch(BASE + 64'(4 * DEPTH));
        fetch(BASE + 64'(4 * (DEPTH - 1)));
        step(1'b0, 1'b1, BASE + 20, 1'b1, 5, 32'hDEAD_BEEF, 4'b0011);
        fetch(BASE + 20);
        step(1'b1, 1'b1, BASE + 4, 1'b0, 0, 32'h0, 4'h0);
        idle();
        fetch(BASE + 4);
        fetch(BASE + 20);

        for (int n = 0; n < 800; n++) begin
            case ($urandom_range(0, 9))
                6:       ra = BASE + 64'(4 * (DEPTH - 1));
                7:       ra = BASE + 64'(4 * $urandom_range(0, 63) + $urandom_range(1, 3));
                8:       ra = BASE - 64'(4 * $urandom_range(1, 100));
                9:       ra = BASE + 64'(4 * DEPTH) + 64'(4 * $urandom_range(0, 1000));
                default: ra = BASE + 64'(4 * $urandom_range(0, 63));
            endcase
            rs = 4'($urandom);
            step(($urandom_range(0, 49) == 0), ($urandom_range(0, 9) < 7), ra,
                 ($urandom_range(0, 9) < 3), $urandom_range(0, 63), $urandom, rs);
        end

        idle();
        @(posedge clk);
        @(posedge clk);
        #2;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/ysyx_22050710_isram.md
# ysyx_22050710_isram

Instruction SRAM responder for the ysyx_22050710 NPC core. It answers the core's inst sram fetch interface (`en`/`addr` in, `rdata` out) with fixed one-cycle read latency from an internal word array. It also:
- accepts a preload write port used by the loader/testbench;
- detects misaligned and out-of-range fetches;
- holds read data stable between fetches.

It sits beside the core at top level, opposite the IF stage's fetch port.

## Interface
Parameters:
- SRAM_ADDR_WD, 64, fetch address width (byte address)
- SRAM_DATA_WD, 32, fetch data width (one instruction)
- DEPTH, 16384, number of 32-bit words in the array
- BASE_ADDR, 64'h8000_0000, byte address of word 0
- FILL_INST, 32'h0000_0000, data returned on a faulting fetch

Ports (one clock; reset is synchronous and active-high):
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- i_inst_sram_en  in  1  fetch request this cycle
- i_inst_sram_addr  in  SRAM_ADDR_WD  fetch byte address
- o_inst_sram_rdata  out  SRAM_DATA_WD  fetched instruction, valid the cycle after request
- i_ld_en  in  1  preload write enable
- i_ld_idx  in  $clog2(DEPTH)  preload word index
- i_ld_data  in  32  preload word
- i_ld_strb  in  4  preload byte strobes (bit k writes byte k)
- o_fault  out  1  sticky: a faulting fetch has occurred since reset
- o_fault_addr  out  SRAM_ADDR_WD  address of the first faulting fetch
- o_fetch_cnt  out  64  accepted fetch count (see Configuration)
- o_fault_cnt  out  32  faulting fetch count (see Configuration)

## Operation
- Offset: off = addr − BASE_ADDR, computed at full SRAM_ADDR_WD width with modulo wrap.
- Fault conditions:
  - misaligned: addr[1:0] != 0;
  - out of range: off ≥ DEPTH*4 (unsigned). Addresses below BASE wrap to huge offsets and therefore fault.
- Normal fetch: the rdata register loads mem[off>>2].
- Faulting fetch:
  - rdata register loads FILL_INST;
  - o_fault sets;
  - o_fault_addr latches addr only if o_fault was 0 (first fault wins).
- No fetch (en=0): the rdata register holds its value.
- Preload:
  - i_ld_en=1 writes the strobed bytes of i_ld_data into mem[i_ld_idx];
  - i_ld_idx ≥ DEPTH is ignored (no write, no fault).
- Same-index collision (fetch and preload in the same cycle): the fetch returns the pre-write word (read-before-write); the new data is visible to fetches from the next cycle.
- Memory array contents are not affected by reset.

## Timing
- Latency: en=1 with addr A in cycle N → o_inst_sram_rdata reflects A from cycle N+1, held until the cycle after the next en=1.
- Back-to-back fetches are supported: one fetch accepted per cycle, no stall, no backpressure.
- Reset values (cycle after i_rst=1): rdata=0, o_fault=0, o_fault_addr=0, o_fetch_cnt=0, o_fault_cnt=0.
- During reset:
  - fetches are ignored;
  - preload writes still take effect, so the loader can fill memory while the core is held in reset.
- Reset asserted mid-stream: a fetch presented in the reset cycle produces no data; rdata reads 0 until the first fetch after reset deasserts.
- Counters saturate at all-ones; they do not wrap.

## Configuration
- YSYX_22050710_ISRAM_PERF_EN defined:
  - o_fetch_cnt increments on every accepted fetch (en=1, not in reset), faulting fetches included;
  - o_fault_cnt increments on every faulting fetch.
- Undefined: no counter registers are built; o_fetch_cnt and o_fault_cnt are tied to 0. The port list is identical in both builds.

## Test plan
- Preload mem[0]=0x00000413, mem[1]=0x00100073; fetch 0x8000_0000 then 0x8000_0004 on consecutive cycles → rdata 0x00000413 then 0x00100073 on the two following cycles; with PERF, o_fetch_cnt=2.
- Fetch 0x8000_0000, then en=0 for 3 cycles → rdata stays 0x00000413 for all 3 cycles.
- Fetch 0x8000_0002, then 0x7FFF_FFFC → rdata FILL_INST both times; o_fault=1; o_fault_addr=0x8000_0002; with PERF, o_fault_cnt=2.
- Fetch BASE+4*DEPTH → fault; fetch BASE+4*(DEPTH−1) → valid data, no new o_fault_addr latch.
- Same cycle: preload idx 5 = 0xDEADBEEF with strb 4'b0011 over old 0x11223344, and fetch BASE+20 → rdata 0x11223344; next fetch of BASE+20 → 0x1122BEEF.
- Mid-run, assert i_rst one cycle with en=1 → next cycle rdata=0, o_fault=0, counters 0; memory retains preloaded words on the next fetch.
